// File: rtl/cursor_nav.sv
// Cursor navigation over a ROWS x COLS menu grid with select/confirm and idle auto-home.
// Latency: every input pulse is reflected on the registered outputs one cycle later.
// Backpressure: none; one pulse per cycle is acted on (sel > back > up > down > left > right).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   up/down/left/right_pulse one-cycle movement requests
//   sel_pulse, back_pulse    one-cycle select/confirm and cancel requests
//   cur_row, cur_col,cur_idx registered cursor position and flat index
//   pending                  high while a selection awaits confirmation
//   item_valid, item_idx     confirmed item pulse and its held index
//   moved, idle_home         cursor-changed and timeout-fired pulses
// Build option: define CURSOR_WRAP_EN to make moves wrap at grid edges
// instead of saturating.
module cursor_nav #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      up_pulse,
  input  logic                      down_pulse,
  input  logic                      left_pulse,
  input  logic                      right_pulse,
  input  logic                      sel_pulse,
  input  logic                      back_pulse,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]               cur_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]               cur_col,
  output logic [((ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1)-1:0] cur_idx,
  output logic                      pending,
  output logic                      item_valid,
  output logic [((ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1)-1:0] item_idx,
  output logic                      moved,
  output logic                      idle_home
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [0:0] {BROWSE, CONFIRM} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] pend_idx, pend_idx_nxt;
  logic [IW-1:0] item_idx_nxt;
  logic [TW-1:0] idle_cnt, idle_cnt_nxt;
  logic          item_valid_nxt, moved_nxt, idle_home_nxt;
  logic          any_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BROWSE;
      cur_row    <= '0;
      cur_col    <= '0;
      cur_idx    <= '0;
      pend_idx   <= '0;
      item_idx   <= '0;
      item_valid <= 1'b0;
      moved      <= 1'b0;
      idle_home  <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cur_row    <= row_nxt;
      cur_col    <= col_nxt;
      cur_idx    <= idx_nxt;
      pend_idx   <= pend_idx_nxt;
      item_idx   <= item_idx_nxt;
      item_valid <= item_valid_nxt;
      moved      <= moved_nxt;
      idle_home  <= idle_home_nxt;
      idle_cnt   <= idle_cnt_nxt;
    end
  end

  assign pending = (state == CONFIRM);

  always_comb begin
    state_nxt      = state;
    row_nxt        = cur_row;
    col_nxt        = cur_col;
    pend_idx_nxt   = pend_idx;
    item_idx_nxt   = item_idx;
    item_valid_nxt = 1'b0;
    moved_nxt      = 1'b0;
    idle_home_nxt  = 1'b0;
    idle_cnt_nxt   = idle_cnt;
    any_in = up_pulse | down_pulse | left_pulse | right_pulse | sel_pulse | back_pulse;

    if (any_in) begin
      // Any pulse, even one that is ignored, counts as user activity.
      idle_cnt_nxt = '0;
      if (sel_pulse) begin
        if (state == BROWSE) begin
          pend_idx_nxt = cur_idx;
          state_nxt    = CONFIRM;
        end else begin
          item_valid_nxt = 1'b1;
          item_idx_nxt   = pend_idx;
          state_nxt      = BROWSE;
        end
      end else if (back_pulse) begin
        state_nxt = BROWSE;
      end else if (state == BROWSE) begin
        if (up_pulse) begin
          if (cur_row != '0)  row_nxt = cur_row - RW'(1);
          else if (WRAP)      row_nxt = RW'(ROWS - 1);
        end else if (down_pulse) begin
          if (cur_row != RW'(ROWS - 1)) row_nxt = cur_row + RW'(1);
          else if (WRAP)                row_nxt = '0;
        end else if (left_pulse) begin
          if (cur_col != '0)  col_nxt = cur_col - CW'(1);
          else if (WRAP)      col_nxt = CW'(COLS - 1);
        end else begin
          if (cur_col != CW'(COLS - 1)) col_nxt = cur_col + CW'(1);
          else if (WRAP)                col_nxt = '0;
        end
        // A wrap on a size-1 dimension lands on the same cell, so no pulse.
        moved_nxt = (row_nxt != cur_row) || (col_nxt != cur_col);
      end
    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
      row_nxt       = '0;
      col_nxt       = '0;
      state_nxt     = BROWSE;
      idle_home_nxt = 1'b1;
      moved_nxt     = (cur_row != '0) || (cur_col != '0);
      idle_cnt_nxt  = '0;
    end else begin
      idle_cnt_nxt = idle_cnt + TW'(1);
    end

    // Index derived from the next position so it registers alongside row/col.
    idx_nxt = IW'(row_nxt) * IW'(COLS) + IW'(col_nxt);
  end

endmodule

// File: tb/tb_cursor_nav.sv
module tb_cursor_nav;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] SEL   = 6'b100000;
  localparam logic [5:0] BACK  = 6'b010000;
  localparam logic [5:0] UP    = 6'b001000;
  localparam logic [5:0] DOWN  = 6'b000100;
  localparam logic [5:0] LEFT  = 6'b000010;
  localparam logic [5:0] RIGHT = 6'b000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_pulse = 1'b0, down_pulse = 1'b0, left_pulse = 1'b0;
  logic       right_pulse = 1'b0, sel_pulse = 1'b0, back_pulse = 1'b0;
  logic [1:0] cur_row, cur_col;
  logic [3:0] cur_idx, item_idx;
  logic       pending, item_valid, moved, idle_home;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cursor_nav #(.ROWS(4), .COLS(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .left_pulse (left_pulse),
    .right_pulse(right_pulse),
    .sel_pulse  (sel_pulse),
    .back_pulse (back_pulse),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .cur_idx    (cur_idx),
    .pending    (pending),
    .item_valid (item_valid),
    .item_idx   (item_idx),
    .moved      (moved),
    .idle_home  (idle_home)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses, then sample 1ns after the edge.
  task automatic step(input logic [5:0] in);
    {sel_pulse, back_pulse, up_pulse, down_pulse, left_pulse, right_pulse} = in;
    @(posedge clk);
    #1;
    {sel_pulse, back_pulse, up_pulse, down_pulse, left_pulse, right_pulse} = NONE;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(NONE);
    step(NONE);
    rst = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int r, input int c);
    chk({tag, ".row"}, 32'(cur_row), r);
    chk({tag, ".col"}, 32'(cur_col), c);
    chk({tag, ".idx"}, 32'(cur_idx), r * 4 + c);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_pos("rst", 0, 0);
    chk("rst.pending", 32'(pending), 0);
    chk("rst.item_valid", 32'(item_valid), 0);
    chk("rst.item_idx", 32'(item_idx), 0);
    chk("rst.moved", 32'(moved), 0);
    chk("rst.idle_home", 32'(idle_home), 0);

    // 1: right x3, down x2 -> (2,3), idx 11, moved every step
    for (int i = 0; i < 3; i++) begin
      step(RIGHT);
      chk("t1.right.moved", 32'(moved), 1);
    end
    for (int i = 0; i < 2; i++) begin
      step(DOWN);
      chk("t1.down.moved", 32'(moved), 1);
    end
    chk_pos("t1", 2, 3);

    // Right edge
    step(RIGHT);
`ifdef CURSOR_WRAP_EN
    chk_pos("edge.right", 2, 0);
    chk("edge.right.moved", 32'(moved), 1);
`else
    chk_pos("edge.right", 2, 3);
    chk("edge.right.moved", 32'(moved), 0);
`endif

    // 2: up at (0,0)
    do_reset();
    step(UP);
`ifdef CURSOR_WRAP_EN
    chk_pos("t2.up", 3, 0);
    chk("t2.moved", 32'(moved), 1);
`else
    chk_pos("t2.up", 0, 0);
    chk("t2.moved", 32'(moved), 0);
`endif

    // 3: select/confirm at (1,2)
    do_reset();
    step(DOWN); step(RIGHT); step(RIGHT);
    chk_pos("t3.start", 1, 2);
    step(SEL);
    chk("t3.sel.pending", 32'(pending), 1);
    chk("t3.sel.item_valid", 32'(item_valid), 0);
    step(RIGHT);
    chk_pos("t3.frozen", 1, 2);
    chk("t3.frozen.moved", 32'(moved), 0);
    step(SEL);
    chk("t3.confirm.item_valid", 32'(item_valid), 1);
    chk("t3.confirm.item_idx", 32'(item_idx), 6);
    chk("t3.confirm.pending", 32'(pending), 0);
    step(NONE);
    chk("t3.after.item_valid", 32'(item_valid), 0);
    chk("t3.after.item_idx", 32'(item_idx), 6);

    // 4: simultaneous sel+up+right, then back
    do_reset();
    step(DOWN); step(RIGHT);
    step(SEL | UP | RIGHT);
    chk("t4.pending", 32'(pending), 1);
    chk_pos("t4.pos", 1, 1);
    chk("t4.moved", 32'(moved), 0);
    step(BACK);
    chk("t4.back.pending", 32'(pending), 0);
    chk("t4.back.item_valid", 32'(item_valid), 0);

    // 5: idle timeout in CONFIRM at (2,2)
    do_reset();
    step(DOWN); step(DOWN); step(RIGHT); step(RIGHT);
    step(SEL);
    chk("t5.pending", 32'(pending), 1);
    for (int i = 0; i < 15; i++) step(NONE);
    chk("t5.early.idle_home", 32'(idle_home), 0);
    chk_pos("t5.early", 2, 2);
    step(NONE);
    chk("t5.idle_home", 32'(idle_home), 1);
    chk("t5.moved", 32'(moved), 1);
    chk("t5.pending", 32'(pending), 0);
    chk_pos("t5.home", 0, 0);
    step(NONE);
    chk("t5.pulse.idle_home", 32'(idle_home), 0);

    // 5b: input on the last idle cycle cancels the timeout
    step(DOWN); step(DOWN); step(RIGHT); step(RIGHT);
    for (int i = 0; i < 15; i++) step(NONE);
    step(LEFT);
    chk("t5b.idle_home", 32'(idle_home), 0);
    chk_pos("t5b.pos", 2, 1);
    chk("t5b.moved", 32'(moved), 1);

    // 6: reset in CONFIRM at (3,3) with sel high
    do_reset();
    for (int i = 0; i < 3; i++) step(DOWN);
    for (int i = 0; i < 3; i++) step(RIGHT);
    step(SEL); step(SEL);
    chk("t6.item_idx", 32'(item_idx), 15);
    step(SEL);
    chk("t6.pending", 32'(pending), 1);
    rst = 1'b1;
    step(SEL);
    rst = 1'b0;
    chk_pos("t6.rst", 0, 0);
    chk("t6.rst.pending", 32'(pending), 0);
    chk("t6.rst.item_valid", 32'(item_valid), 0);
    chk("t6.rst.item_idx", 32'(item_idx), 0);
    chk("t6.rst.moved", 32'(moved), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
